score_display_counter: RTL and testbench
========================================

SCORE_DISPLAY_COUNTER -- requirements
Module: score_display_counter

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, is the number of clk_1mhz cycles each digit is displayed (1 ms at 1 MHz).
REQ-002 Parameter BLANK_LZ, default 1; when 1, the tens digit is blanked while it is 0.
REQ-003 clk_1mhz  input  1  is the single system clock at 1 MHz; all state changes on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 count_up  input  1  is the synchronous level pulse (nominally 1000 cycles wide) that requests score +1.
REQ-006 count_down  input  1  is the synchronous level pulse (nominally 1000 cycles wide) that requests score -1.
REQ-007 score_bcd  output  8  is the current score in BCD, {tens[3:0], ones[3:0]}, range 00..99.
REQ-008 seg  output  7  is the active-high segment drive {g,f,e,d,c,b,a} for the currently selected digit.
REQ-009 digit_sel  output  2  is the one-hot active-high digit enable: 2'b01 selects ones, 2'b10 selects tens.

Function
REQ-010 The block SHALL register count_up and count_down each cycle (up_q, dn_q) and detect rising edges as input=1 and _q=0.
REQ-011 An up edge without a down edge in the same cycle SHALL increment score_bcd by 1 in BCD on that clock edge, with a new value visible in the following cycle.
REQ-012 A down edge without an up edge in the same cycle SHALL decrement score_bcd by 1 in BCD on that clock edge.
REQ-013 Simultaneous up and down edges in the same cycle SHALL leave score_bcd unchanged.
REQ-014 Holding an input high SHALL produce exactly one step; no further step occurs until the input falls and rises again.
REQ-015 Increment SHALL carry ones 9->0 with tens+1 (e.g. 09->10, 49->50).
REQ-016 Increment at 99 SHALL saturate and hold 99.
REQ-017 Decrement SHALL borrow ones 0->9 with tens-1 (e.g. 10->09).
REQ-018 Decrement at 00 SHALL saturate and hold 00.
REQ-019 Each BCD nibble SHALL only ever hold 0..9.
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-021 On each wrap the refresh counter SHALL toggle the active digit between ones and tens; the active digit starts at ones.
REQ-022 digit_sel and seg SHALL be registered and reflect the active digit and the current score one cycle after either changes.
REQ-023 The segment encoding for digits 0..9 SHALL be 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex, seg[6:0]).
REQ-024 When tens is selected, tens=0 and BLANK_LZ=1, seg SHALL be 7'h00 while digit_sel still shows 2'b10.
REQ-025 A score change mid-refresh-period SHALL NOT restart or alter the refresh counter or the active digit.

Reset
REQ-026 While reset=1, score_bcd SHALL be 8'h00.
REQ-027 While reset=1, up_q and dn_q SHALL be 0.
REQ-028 While reset=1, the refresh counter SHALL be 0 and the active digit SHALL be ones.
REQ-029 While reset=1, digit_sel SHALL be 2'b01 and seg SHALL be 7'h3F.
REQ-030 Reset asserted mid-pulse SHALL clear state immediately without waiting for a clock edge.
REQ-031 If count_up is already high when reset deasserts, the block SHALL take no step (up_q is 0 but the edge is ignored for the first cycle after reset); a step requires a fresh 0->1 transition.

Verification
REQ-032 Reset, then 12 count_up pulses of 1000 cycles spaced 500 cycles apart -> score_bcd=8'h12; each pulse produces exactly one step.
REQ-033 Preload to 8'h99 via 99 up pulses, then 2 more up pulses -> score_bcd stays 8'h99; then 1 down pulse -> 8'h98.
REQ-034 From 8'h10, 1 down pulse -> 8'h09; from 8'h00, 1 down pulse -> stays 8'h00.
REQ-035 count_up and count_down rise on the same cycle at score 8'h05 -> score_bcd stays 8'h05; later isolated up pulse -> 8'h06.
REQ-036 Score 8'h07, BLANK_LZ=1, run 3000 cycles -> digit_sel alternates 01/10 every 1000 cycles; seg=7'h07 with ones selected, 7'h00 with tens selected.
REQ-037 Assert reset mid count_up pulse at score 8'h42 -> score_bcd=8'h00, digit_sel=2'b01, seg=7'h3F asynchronously; the remaining high portion of the pulse causes no step.

Source files
------------

// File: rtl/score_display_counter.sv
// score_display_counter
// Two-digit BCD up/down score counter with saturation at 00 and 99, driving a
// time-multiplexed two-digit seven-segment display.
//
// Ports:
//   clk_1mhz   in   1  system clock (1 MHz), all state on rising edge
//   reset      in   1  asynchronous active-high reset
//   count_up   in   1  level pulse; each rising edge requests score +1
//   count_down in   1  level pulse; each rising edge requests score -1
//   score_bcd  out  8  current score {tens, ones} in BCD, 00..99
//   seg        out  7  active-high segments {g,f,e,d,c,b,a} of selected digit
//   digit_sel  out  2  one-hot digit enable: 01 = ones, 10 = tens
module score_display_counter #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk_1mhz,
  input  logic       reset,
  input  logic       count_up,
  input  logic       count_down,
  output logic [7:0] score_bcd,
  output logic [6:0] seg,
  output logic [1:0] digit_sel
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic             up_q;
  logic             dn_q;
  logic             armed;      // low for the first cycle after reset
  logic             up_edge;
  logic             dn_edge;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [7:0]       score_nxt;
  logic [CNT_W-1:0] refresh_cnt;
  logic             refresh_wrap;
  logic             tens_active;
  logic [3:0]       shown_digit;
  logic [6:0]       seg_nxt;
  logic [1:0]       digit_sel_nxt;

  // Seven-segment encoding of a BCD digit
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h3F;
      4'd1:    seg_enc = 7'h06;
      4'd2:    seg_enc = 7'h5B;
      4'd3:    seg_enc = 7'h4F;
      4'd4:    seg_enc = 7'h66;
      4'd5:    seg_enc = 7'h6D;
      4'd6:    seg_enc = 7'h7D;
      4'd7:    seg_enc = 7'h07;
      4'd8:    seg_enc = 7'h7F;
      4'd9:    seg_enc = 7'h6F;
      default: seg_enc = 7'h00;
    endcase
  endfunction

  assign ones = score_bcd[3:0];
  assign tens = score_bcd[7:4];

  // Edges are ignored in the first cycle after reset so an input already high
  // at reset release never counts as a fresh transition.
  assign up_edge = armed & count_up & ~up_q;
  assign dn_edge = armed & count_down & ~dn_q;

  // Next BCD score: single step with carry/borrow, saturating at 00 and 99
  always_comb begin
    score_nxt = score_bcd;
    if (up_edge && !dn_edge) begin
      if (score_bcd == 8'h99) begin
        score_nxt = score_bcd;
      end else if (ones == 4'd9) begin
        score_nxt = {4'(tens + 4'd1), 4'd0};
      end else begin
        score_nxt = {tens, 4'(ones + 4'd1)};
      end
    end else if (dn_edge && !up_edge) begin
      if (score_bcd == 8'h00) begin
        score_nxt = score_bcd;
      end else if (ones == 4'd0) begin
        score_nxt = {4'(tens - 4'd1), 4'd9};
      end else begin
        score_nxt = {tens, 4'(ones - 4'd1)};
      end
    end
  end

  // Input history and score register
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      armed     <= 1'b0;
      score_bcd <= 8'h00;
    end else begin
      up_q      <= count_up;
      dn_q      <= count_down;
      armed     <= 1'b1;
      score_bcd <= score_nxt;
    end
  end

  assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  // Free-running refresh timer; independent of score activity
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      tens_active <= 1'b0;
    end else if (refresh_wrap) begin
      refresh_cnt <= '0;
      tens_active <= ~tens_active;
    end else begin
      refresh_cnt <= CNT_W'(refresh_cnt + CNT_W'(1));
    end
  end

  // Display decode for the active digit, with optional leading-zero blanking
  always_comb begin
    shown_digit   = tens_active ? tens : ones;
    digit_sel_nxt = tens_active ? 2'b10 : 2'b01;
    seg_nxt       = seg_enc(shown_digit);
    if (tens_active && BLANK_LZ && (tens == 4'd0)) begin
      seg_nxt = 7'h00;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      digit_sel <= 2'b01;
      seg       <= 7'h3F;
    end else begin
      digit_sel <= digit_sel_nxt;
      seg       <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_score_display_counter.sv
// Testbench for score_display_counter: a behavioural model tracks the score as
// an integer and the display phase from the cycle count since reset.
module tb_score_display_counter;

  localparam int unsigned DIV = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       count_up = 1'b0;
  logic       count_down = 1'b0;
  logic [7:0] score_bcd;
  logic [6:0] seg;
  logic [1:0] digit_sel;

  int vectors = 0;
  int miscompares = 0;

  score_display_counter #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk_1mhz  (clk),
    .reset     (reset),
    .count_up  (count_up),
    .count_down(count_down),
    .score_bcd (score_bcd),
    .seg       (seg),
    .digit_sel (digit_sel)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         ms;
  int         n;
  bit         prev_up, prev_dn, armed;
  logic [1:0] exp_sel;
  logic [6:0] exp_seg;

  always @(posedge clk or posedge reset) begin
    bit tens_on, ue, de;
    if (reset) begin
      ms = 0; n = 0; prev_up = 0; prev_dn = 0; armed = 0;
      exp_sel = 2'b01; exp_seg = 7'h3F;
    end else begin
      tens_on = ((n / DIV) % 2) == 1;
      exp_sel = tens_on ? 2'b10 : 2'b01;
      if (tens_on) exp_seg = (ms / 10 == 0) ? 7'h00 : seg_tbl[ms / 10];
      else         exp_seg = seg_tbl[ms % 10];
      ue = armed && count_up && !prev_up;
      de = armed && count_down && !prev_dn;
      if (ue && !de && ms < 99) ms = ms + 1;
      else if (de && !ue && ms > 0) ms = ms - 1;
      prev_up = count_up; prev_dn = count_down; armed = 1; n = n + 1;
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic pulse(input bit up, input bit dn, input int w, input int g);
    @(negedge clk); count_up = up; count_down = dn;
    repeat (w) @(negedge clk);
    count_up = 1'b0; count_down = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic short_ups(input int k);
    for (int i = 0; i < k; i++) pulse(1, 0, $urandom_range(1, 4), $urandom_range(1, 3));
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (score_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_score got %h exp 00", score_bcd); end
    vectors++; if (digit_sel !== 2'b01) begin miscompares++; $display("FAIL reset_sel got %b exp 01", digit_sel); end
    vectors++; if (seg !== 7'h3F) begin miscompares++; $display("FAIL reset_seg got %h exp 3f", seg); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_count_up_long();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      pulse(1, 0, 1000, 500);
      vectors++;
      if (score_bcd !== to_bcd(i)) begin
        miscompares++; $display("FAIL long_pulse_%0d got %h exp %h", i, score_bcd, to_bcd(i));
      end
    end
    vectors++; if (score_bcd !== 8'h12) begin miscompares++; $display("FAIL long_final got %h exp 12", score_bcd); end
  endtask

  task automatic test_saturate_high();
    do_reset();
    short_ups(99);
    vectors++; if (score_bcd !== 8'h99) begin miscompares++; $display("FAIL preload99 got %h exp 99", score_bcd); end
    short_ups(2);
    vectors++; if (score_bcd !== 8'h99) begin miscompares++; $display("FAIL sat99 got %h exp 99", score_bcd); end
    pulse(0, 1, 3, 2);
    vectors++; if (score_bcd !== 8'h98) begin miscompares++; $display("FAIL down98 got %h exp 98", score_bcd); end
  endtask

  task automatic test_borrow_and_floor();
    do_reset();
    short_ups(10);
    vectors++; if (score_bcd !== 8'h10) begin miscompares++; $display("FAIL pre10 got %h exp 10", score_bcd); end
    pulse(0, 1, 2, 2);
    vectors++; if (score_bcd !== 8'h09) begin miscompares++; $display("FAIL borrow09 got %h exp 09", score_bcd); end
    for (int i = 0; i < 9; i++) pulse(0, 1, $urandom_range(1, 4), $urandom_range(1, 3));
    vectors++; if (score_bcd !== 8'h00) begin miscompares++; $display("FAIL down00 got %h exp 00", score_bcd); end
    pulse(0, 1, 5, 2);
    vectors++; if (score_bcd !== 8'h00) begin miscompares++; $display("FAIL sat00 got %h exp 00", score_bcd); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    short_ups(5);
    pulse(1, 1, 6, 3);
    vectors++; if (score_bcd !== 8'h05) begin miscompares++; $display("FAIL simul got %h exp 05", score_bcd); end
    pulse(1, 0, 4, 3);
    vectors++; if (score_bcd !== 8'h06) begin miscompares++; $display("FAIL after_simul got %h exp 06", score_bcd); end
  endtask

  task automatic test_display();
    logic [1:0] prev_sel;
    int last_change, changes;
    do_reset();
    short_ups(7);
    repeat (5) @(negedge clk);
    prev_sel = digit_sel; last_change = -1; changes = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      vectors++;
      if (digit_sel !== exp_sel || seg !== exp_seg) begin
        miscompares++; $display("FAIL disp_model c=%0d got %b/%h exp %b/%h", c, digit_sel, seg, exp_sel, exp_seg);
      end
      vectors++;
      if (!((digit_sel === 2'b01 && seg === 7'h07) || (digit_sel === 2'b10 && seg === 7'h00))) begin
        miscompares++; $display("FAIL disp_pair c=%0d got sel %b seg %h", c, digit_sel, seg);
      end
      if (digit_sel !== prev_sel) begin
        if (last_change >= 0) begin
          vectors++;
          if (c - last_change != int'(DIV)) begin
            miscompares++; $display("FAIL disp_period got %0d exp %0d", c - last_change, DIV);
          end
        end
        last_change = c; changes++; prev_sel = digit_sel;
      end
    end
    vectors++; if (changes < 2) begin miscompares++; $display("FAIL disp_toggles got %0d exp >=2", changes); end
  endtask

  task automatic test_random();
    do_reset();
    short_ups(45);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) count_up = ~count_up;
      if ($urandom_range(0, 7) == 0) count_down = ~count_down;
      vectors++;
      if (score_bcd !== to_bcd(ms) || digit_sel !== exp_sel || seg !== exp_seg) begin
        miscompares++;
        $display("FAIL random c=%0d got %h/%b/%h exp %h/%b/%h", c, score_bcd, digit_sel, seg, to_bcd(ms), exp_sel, exp_seg);
      end
    end
    count_up = 1'b0; count_down = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    short_ups(42);
    vectors++; if (score_bcd !== 8'h42) begin miscompares++; $display("FAIL pre42 got %h exp 42", score_bcd); end
    @(negedge clk); count_up = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++; if (score_bcd !== 8'h00) begin miscompares++; $display("FAIL async_score got %h exp 00", score_bcd); end
    vectors++; if (digit_sel !== 2'b01) begin miscompares++; $display("FAIL async_sel got %b exp 01", digit_sel); end
    vectors++; if (seg !== 7'h3F) begin miscompares++; $display("FAIL async_seg got %h exp 3f", seg); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (score_bcd !== 8'h00) begin miscompares++; $display("FAIL held_through_reset got %h exp 00", score_bcd); end
    count_up = 1'b0;
    repeat (3) @(negedge clk);
    pulse(1, 0, 3, 2);
    vectors++; if (score_bcd !== 8'h01) begin miscompares++; $display("FAIL fresh_edge got %h exp 01", score_bcd); end
  endtask

  initial begin
    test_reset();
    test_count_up_long();
    test_saturate_high();
    test_borrow_and_floor();
    test_simultaneous();
    test_display();
    test_random();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
